// File: rtl/bsg_age_arb_tracked.sv
// Age-based arbiter with internally tracked per-requester waiting time.
// Grants the oldest requester when ready_i is high. Ties go round-robin
// from rr_ptr_r. An optional lock holds the previous grant, and
// starved_o flags requesters whose age counter has saturated.
module bsg_age_arb_tracked #(
   parameter int unsigned inputs_p    = 4,
   parameter int unsigned age_width_p = 4
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                ready_i,
   input  logic                lock_i,
   input  logic [inputs_p-1:0] reqs_i,
   output logic [inputs_p-1:0] grants_o,
   output logic                v_o,
   output logic [inputs_p-1:0] starved_o
);

   localparam int unsigned ptr_w = (inputs_p > 1) ? $clog2(inputs_p) : 1;
   localparam logic [age_width_p-1:0] age_max = '1;

   logic [age_width_p-1:0] age_r [inputs_p];
   logic [ptr_w-1:0]       rr_ptr_r;
   logic [inputs_p-1:0]    last_r;
   logic                   last_v_r;

   logic                   lock_hit;
   logic                   found;
   logic [age_width_p-1:0] best_age;
   logic [ptr_w-1:0]       best_idx;
   logic [ptr_w-1:0]       scan_idx;
   int unsigned            scan_sum;
   logic [inputs_p-1:0]    pick;
   logic [ptr_w-1:0]       grant_idx;
   logic [ptr_w-1:0]       next_ptr;

   // Oldest-requester search, scanning circularly from rr_ptr_r so the
   // strict '>' leaves the first tied index at or after the pointer.
   always_comb begin
      found    = 1'b0;
      best_age = '0;
      best_idx = '0;
      scan_idx = '0;
      scan_sum = 0;
      pick     = '0;
      for (int unsigned k = 0; k < inputs_p; k++) begin
         scan_sum = 32'(rr_ptr_r) + k;
         if (scan_sum >= inputs_p) scan_sum = scan_sum - inputs_p;
         scan_idx = ptr_w'(scan_sum);
         if (reqs_i[scan_idx] && (!found || (age_r[scan_idx] > best_age))) begin
            found    = 1'b1;
            best_age = age_r[scan_idx];
            best_idx = scan_idx;
         end
      end
      if (found) pick[best_idx] = 1'b1;
   end

   // Final grant: lock override, else age pick; gated by reset and ready.
   always_comb begin
      lock_hit = lock_i & last_v_r & (|(reqs_i & last_r));
      grants_o = '0;
      if (reset_n_i && ready_i) begin
         if (lock_hit) grants_o = last_r;
         else          grants_o = pick;
      end
      v_o = |grants_o;
   end

   // Pointer advance to one past the granted index (locked grants included).
   always_comb begin
      grant_idx = '0;
      for (int unsigned k = 0; k < inputs_p; k++) begin
         if (grants_o[k]) grant_idx = ptr_w'(k);
      end
      if ((32'(grant_idx) + 1) >= inputs_p) next_ptr = '0;
      else                                  next_ptr = grant_idx + 1'b1;
   end

   // Starvation flags: saturated age on a live request, forced low in reset.
   always_comb begin
      starved_o = '0;
      for (int unsigned i = 0; i < inputs_p; i++) begin
         starved_o[i] = reset_n_i & reqs_i[i] & (age_r[i] == age_max);
      end
   end

   // Age counters, round-robin pointer and last-grant record.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         for (int unsigned i = 0; i < inputs_p; i++) age_r[i] <= '0;
         rr_ptr_r <= '0;
         last_r   <= '0;
         last_v_r <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < inputs_p; i++) begin
            if (!reqs_i[i] || grants_o[i]) age_r[i] <= '0;
            else if (age_r[i] != age_max)   age_r[i] <= age_r[i] + 1'b1;
         end
         if (v_o) begin
            rr_ptr_r <= next_ptr;
            last_r   <= grants_o;
            last_v_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bsg_age_arb_tracked.sv
// Bench for bsg_age_arb_tracked: vector table with a scoreboard queue,
// followed by a fairness sweep over every request pattern.
module tb_bsg_age_arb_tracked;

   logic       clk;
   logic       reset_n;
   logic       ready;
   logic       lock;
   logic [3:0] reqs;
   logic [3:0] grants;
   logic       v;
   logic [3:0] starved;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       rst_n;
      logic       rdy;
      logic       lck;
      logic [3:0] rq;
      logic [3:0] exp_g;
      logic [3:0] exp_s;
   } vec_t;

   typedef struct {
      logic [3:0] g;
      logic       vv;
      logic [3:0] s;
      int         id;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   bsg_age_arb_tracked #(
      .inputs_p   (4),
      .age_width_p(2)
   ) dut (
      .clk_i    (clk),
      .reset_n_i(reset_n),
      .ready_i  (ready),
      .lock_i   (lock),
      .reqs_i   (reqs),
      .grants_o (grants),
      .v_o      (v),
      .starved_o(starved)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic add(input logic r, input logic rd, input logic lk,
                      input logic [3:0] rq, input logic [3:0] g, input logic [3:0] s);
      vec_t t;
      t.rst_n = r; t.rdy = rd; t.lck = lk; t.rq = rq; t.exp_g = g; t.exp_s = s;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input int id, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec=%0d actual=%b required=%b", name, id, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input int id);
      exp_t e;
      reset_n = t.rst_n;
      ready   = t.rdy;
      lock    = t.lck;
      reqs    = t.rq;
      sb.push_back('{g: t.exp_g, vv: |t.exp_g, s: t.exp_s, id: id});
      #2;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", id);
      end else begin
         total--;
         e = sb.pop_front();
         chk("grants",  e.id, grants,  e.g);
         chk("v",       e.id, {3'b0, v}, {3'b0, e.vv});
         chk("starved", e.id, starved, e.s);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt[4];
      int lo;
      int hi;
      int pc;
      logic [3:0] pat;

      reset_n = 1'b0; ready = 1'b0; lock = 1'b0; reqs = '0;

      // reset
      add(0,1,0,4'hF,4'h0,4'h0);
      add(0,1,0,4'hF,4'h0,4'h0);
      // all-request round robin; starved tracks the saturated oldest
      add(1,1,0,4'hF,4'h1,4'h0);
      add(1,1,0,4'hF,4'h2,4'h0);
      add(1,1,0,4'hF,4'h4,4'h0);
      add(1,1,0,4'hF,4'h8,4'h8);
      add(1,1,0,4'hF,4'h1,4'h1);
      add(1,1,0,4'hF,4'h2,4'h2);
      add(1,1,0,4'hF,4'h4,4'h4);
      add(1,1,0,4'hF,4'h8,4'h8);
      // reset mid-stream
      add(0,1,0,4'hF,4'h0,4'h0);
      add(1,1,0,4'hF,4'h1,4'h0);
      // idle, then oldest wins
      add(1,1,0,4'h0,4'h0,4'h0);
      add(1,0,0,4'h2,4'h0,4'h0);
      add(1,0,0,4'h2,4'h0,4'h0);
      add(1,0,0,4'h2,4'h0,4'h0);
      add(1,1,0,4'h3,4'h2,4'h2);
      add(1,1,0,4'h3,4'h1,4'h0);
      // saturation and starvation
      add(1,0,0,4'h4,4'h0,4'h0);
      add(1,0,0,4'h4,4'h0,4'h0);
      add(1,0,0,4'h4,4'h0,4'h0);
      add(1,0,0,4'h4,4'h0,4'h4);
      add(1,0,0,4'h4,4'h0,4'h4);
      add(1,1,0,4'h4,4'h4,4'h4);
      add(1,0,0,4'h4,4'h0,4'h0);
      // lock
      add(0,1,0,4'hF,4'h0,4'h0);
      add(1,1,1,4'hF,4'h1,4'h0);
      add(1,1,1,4'hF,4'h1,4'h0);
      add(1,1,1,4'hF,4'h1,4'h0);
      add(1,1,1,4'hF,4'h1,4'hE);
      add(1,1,1,4'hE,4'h2,4'hE);
      add(1,1,1,4'hE,4'h2,4'hC);
      add(1,1,0,4'hE,4'h4,4'hC);
      add(1,0,1,4'hE,4'h0,4'h8);
      add(1,1,1,4'hE,4'h4,4'h8);
      // clean state for the sweep
      add(0,1,0,4'h0,4'h0,4'h0);

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // fairness sweep: each pattern held for 8 ready cycles
      for (int p = 0; p < 16; p++) begin
         pat = 4'(p);
         for (int i = 0; i < 4; i++) cnt[i] = 0;
         for (int c = 0; c < 8; c++) begin
            reset_n = 1'b1; ready = 1'b1; lock = 1'b0; reqs = pat;
            #2;
            chk("sweep_subset", p, grants & ~pat, 4'h0);
            chk("sweep_onehot", p, 4'($countones(grants)), (pat != 0) ? 4'h1 : 4'h0);
            chk("sweep_v", p, {3'b0, v}, {3'b0, (pat != 0)});
            for (int i = 0; i < 4; i++) if (grants[i]) cnt[i]++;
            @(posedge clk);
            #1;
         end
         pc = $countones(pat);
         for (int i = 0; i < 4; i++) begin
            if (pat[i]) begin
               lo = 8 / pc;
               hi = lo + 1;
            end else begin
               lo = 0;
               hi = 0;
            end
            total++;
            if (cnt[i] < lo || cnt[i] > hi) begin
               bad++;
               $display("FAIL sweep_count pat=%b in=%0d actual=%0d required=%0d..%0d",
                        pat, i, cnt[i], lo, hi);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
